// File: rtl/ext_bus_ctrl.sv
// ext_bus_ctrl: external-bus controller with a base/mask region table,
// per-region wait states and write permission, and bus-lock ownership pinning.
module ext_bus_ctrl #(
  parameter int                         ADDR_W    = 16,
  parameter int                         DATA_W    = 16,
  parameter int                         NUM_REG   = 2,
  parameter logic [NUM_REG*ADDR_W-1:0]  REG_BASE  = {16'h1000, 16'h0000},
  parameter logic [NUM_REG*ADDR_W-1:0]  REG_MASK  = {16'hF000, 16'hFF00},
  parameter logic [NUM_REG*4-1:0]       REG_WAIT  = {4'd2, 4'd0},
  parameter logic [NUM_REG-1:0]         REG_WR_EN = 2'b10
) (
  input  logic                        sys_clk,
  input  logic                        sys_n_rst,
  input  logic                        i_bus_req,
  input  logic                        i_bus_rw,
  input  logic [ADDR_W-1:0]           i_bus_addr,
  input  logic [DATA_W-1:0]           i_bus_wdata,
  input  logic                        i_bus_lock,
  output logic [DATA_W-1:0]           o_bus_rdata,
  output logic                        o_bus_ready,
  output logic                        o_bus_err,
  output logic [NUM_REG-1:0]          o_mem_sel,
  output logic [ADDR_W-1:0]           o_mem_addr,
  output logic [DATA_W-1:0]           o_mem_wdata,
  output logic                        o_mem_we,
  input  logic [NUM_REG*DATA_W-1:0]   i_mem_rdata,
  output logic                        o_locked,
  output logic [ADDR_W-1:0]           o_err_addr
);

  localparam int IDX_W = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [3:0]          r_cnt;
  logic                r_rw;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    r_lock_idx;
  logic                r_locked;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [NUM_REG-1:0]  r_sel;
  logic                r_err;
  logic [ADDR_W-1:0]   r_err_addr;

  logic [NUM_REG-1:0]  w_hit;
  logic [3:0]          w_wait_tab  [NUM_REG];
  logic [DATA_W-1:0]   w_rdata_ch  [NUM_REG];
  logic                w_any_hit;
  logic [IDX_W-1:0]    w_hit_idx;
  logic                w_req_err;
  logic                w_cnt_zero;

  // Per-region address compare and unpacking of the packed tables.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REG; gi++) begin : g_region
      assign w_hit[gi] = ((i_bus_addr & REG_MASK[gi*ADDR_W +: ADDR_W]) ==
                          (REG_BASE[gi*ADDR_W +: ADDR_W] & REG_MASK[gi*ADDR_W +: ADDR_W]));
      assign w_wait_tab[gi] = REG_WAIT[gi*4 +: 4];
      assign w_rdata_ch[gi] = i_mem_rdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Priority encode the hits so that the lowest-index region wins on overlap.
  always_comb begin
    w_any_hit = 1'b0;
    w_hit_idx = '0;
    for (int k = NUM_REG - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_any_hit = 1'b1;
        w_hit_idx = IDX_W'(k);
      end
    end
  end

  // A request errors on a miss, a write to a read-only region, or a lock conflict.
  assign w_req_err = !w_any_hit
                   | (i_bus_rw && !REG_WR_EN[w_hit_idx])
                   | (r_locked && (w_hit_idx != r_lock_idx));

  assign w_cnt_zero = (r_cnt == 4'd0);

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_n_rst) begin
    if (!sys_n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: errors skip ACCESS and go straight to the ACK strobe.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_bus_req) begin
          w_state_next = w_req_err ? S_ACK : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (w_cnt_zero) begin
          w_state_next = S_ACK;
        end
      end
      S_ACK:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: request latching, wait counting, read capture and lock tracking.
  always_ff @(posedge sys_clk or negedge sys_n_rst) begin
    if (!sys_n_rst) begin
      r_cnt      <= '0;
      r_rw       <= 1'b0;
      r_idx      <= '0;
      r_lock_idx <= '0;
      r_locked   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_sel      <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!i_bus_lock) begin
            r_locked <= 1'b0;
          end
          if (i_bus_req) begin
            r_addr  <= i_bus_addr;
            r_wdata <= i_bus_wdata;
            r_rw    <= i_bus_rw;
            if (w_req_err) begin
              r_err      <= 1'b1;
              r_err_addr <= i_bus_addr;
              r_sel      <= '0;
              if (!i_bus_rw) begin
                r_rdata <= '0;
              end
            end else begin
              r_err <= 1'b0;
              r_idx <= w_hit_idx;
              r_cnt <= w_wait_tab[w_hit_idx];
              r_sel <= NUM_REG'(1) << w_hit_idx;
            end
          end
        end
        S_ACCESS: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (!r_rw) begin
              r_rdata <= w_rdata_ch[r_idx];
            end
            r_sel <= '0;
            if (i_bus_lock) begin
              r_locked   <= 1'b1;
              r_lock_idx <= r_idx;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_bus_ready = (r_state == S_ACK);
  assign o_mem_we    = (r_state == S_ACCESS) && w_cnt_zero && r_rw;
  assign o_bus_rdata = r_rdata;
  assign o_bus_err   = r_err;
  assign o_mem_sel   = r_sel;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_locked    = r_locked;
  assign o_err_addr  = r_err_addr;

endmodule

// File: doc/ext_bus_ctrl.md
# ext_bus_ctrl

Parametrised external-bus memory controller between the 16-bit CPU bus and up to `NUM_REG` memory/peripheral channels. It replaces fixed ROM/RAM address decoding with a table of base/mask regions, each with its own wait-state count and write permission. It adds a ready/error handshake and honours the bus-lock signal by pinning ownership to one region. It sits directly behind the CPU bus pins, with all bus traffic passing through it.

## Interface
Parameters:
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `NUM_REG`, 2, number of regions/channels (1..8)
- `REG_BASE`, {16'h1000,16'h0000}, packed NUM_REG*ADDR_W region bases, region 0 in LSBs
- `REG_MASK`, {16'hF000,16'hFF00}, packed NUM_REG*ADDR_W compare masks
- `REG_WAIT`, {4'd2,4'd0}, packed NUM_REG*4 wait states W (0..15)
- `REG_WR_EN`, 2'b10, per-region write permission bit

Ports (one clock; reset is asynchronous and active-low):
- `sys_clk`  in  1  system clock
- `sys_n_rst`  in  1  asynchronous active-low reset
- `i_bus_req`  in  1  access request, sampled only in IDLE
- `i_bus_rw`  in  1  1 = write, 0 = read
- `i_bus_addr`  in  ADDR_W  access address
- `i_bus_wdata`  in  DATA_W  write data
- `i_bus_lock`  in  1  CPU bus lock
- `o_bus_rdata`  out  DATA_W  registered read data, valid with ready
- `o_bus_ready`  out  1  one-cycle completion strobe
- `o_bus_err`  out  1  error flag, valid with ready
- `o_mem_sel`  out  NUM_REG  one-hot channel select
- `o_mem_addr`  out  ADDR_W  latched address
- `o_mem_wdata`  out  DATA_W  latched write data
- `o_mem_we`  out  1  write strobe
- `i_mem_rdata`  in  NUM_REG*DATA_W  packed channel read data
- `o_locked`  out  1  lock held, status
- `o_err_addr`  out  ADDR_W  address of the last errored access

## Operation
- Hit rule: region k hits when (addr & MASK_k) == (BASE_k & MASK_k). On overlap, the lowest index wins.
- FSM states: IDLE, ACCESS, ACK.
- IDLE with `i_bus_req`=1: latch addr, rw and wdata, then decode.
  - Valid hit: go to ACCESS. Load the counter with W_k. Drive `o_mem_sel` one-hot k, plus `o_mem_addr` and `o_mem_wdata`.
  - Error: go to ACK with err=1, select nothing, and load `o_err_addr`. Error conditions are:
    - no region hits;
    - write to a region with REG_WR_EN=0;
    - locked and the hit region differs from the locked region.
- ACCESS:
  - counter != 0: decrement.
  - counter == 0:
    - read: capture `i_mem_rdata[k]` into `o_bus_rdata`;
    - write: assert `o_mem_we` for exactly this cycle;
    - then go to ACK.
- ACK: `o_bus_ready`=1 for one cycle, `o_mem_sel` cleared, then return to IDLE.
- A request present during ACCESS or ACK is ignored. A level-held `i_bus_req` starts a new access on the first IDLE cycle.
- Lock behaviour:
  - Lock is taken on a successful completion with `i_bus_lock`=1. `o_locked`=1 and the locked region is recorded.
  - Lock is released in IDLE when `i_bus_lock`=0.
  - An errored access never takes the lock.
- Errored reads return `o_bus_rdata`=0.
- Errored writes never assert `o_mem_we`.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0, including rdata, ready, err, sel, addr, wdata, we, locked and err_addr.
- Sampling edge E0. Valid access: ACCESS occupies cycles 1..W+1 after E0. `o_mem_we` is high in cycle W+1. `o_bus_ready` is high in cycle W+2.
- Error: `o_bus_ready` and `o_bus_err` are high in cycle 1 after E0.
- Throughput:
  - back-to-back valid accesses: W+3 cycles each;
  - back-to-back errors: 2 cycles each.
- `o_bus_rdata` holds its value until the next read completes. `o_err_addr` holds until the next error.
- Reset mid-ACCESS aborts the access. No `o_mem_we` pulse occurs after reset assertion, and the lock is dropped.
- Counter width is 4 bits and never wraps: the decrement is skipped at 0.

## Test plan
- ROM read 0x0010, channel 0 returns 16'hA5A5 -> sel=2'b01 in cycle 1; ready=1, rdata=16'hA5A5, err=0 in cycle 2.
- RAM write 0x1234, data 16'hBEEF -> sel=2'b10 in cycles 1-3, we=1 only in cycle 3 with mem_addr=0x1234 and mem_wdata=16'hBEEF; ready in cycle 4.
- Write to ROM 0x0020 -> ready=1, err=1 in cycle 1; we never asserted; err_addr=0x0020.
- Read unmapped 0x8000 -> ready=1, err=1 in cycle 1; rdata=0; sel stays 0.
- Locked sequence:
  - lock=1, read 0x1000 -> locked=1;
  - then read 0x0000 -> err=1;
  - lock=0 for one IDLE cycle -> locked=0;
  - read 0x0000 -> err=0.
- Reset asserted in cycle 2 of a RAM write -> all outputs 0 immediately, no we pulse; a subsequent RAM read completes normally with ready in cycle 4.
